store_size_seq: RTL and testbench

- Multicycle sequencer for sub-word stores.
- Accepts a store request (address, size) and drives the memory port and MDR load enable, plus the 2-bit size select of the store-merge unit.
- Halfword and byte stores become read-modify-write: read the word, latch it into MDR, then write the merged word. Word stores write directly.
- Sits between the main control FSM and the memory / MDR / store-merge datapath. The datapath carries the data; this block carries control only.

---
 rtl/store_size_seq_pkg.sv | 24 ++
 rtl/store_size_seq_rd_wait_cnt.sv | 36 +++
 rtl/store_size_seq.sv | 127 ++++++++++++
 tb/tb_store_size_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/store_size_seq_pkg.sv
// Shared definitions for the sub-word store sequencer.
//   - size encodings presented on st_size / ssize_ctrl
//   - sequencer state encoding
//   - width helper for the read-latency wait counter
package store_size_seq_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      ERR   = 3'd4
   } state_t;

   // Enough bits to hold RD_LAT-1, plus one so RD_LAT=1 still gets a 1-bit counter.
   function automatic int wait_cnt_w(input int lat);
      return $clog2(lat) + 1;
   endfunction

endpackage

// File: rtl/store_size_seq_rd_wait_cnt.sv
// Loadable down-counter used to wait out the memory read latency.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load RD_LAT-1 (takes priority over dec)
//   dec        : decrement by one, saturating at zero
//   zero       : counter currently equals zero
module rd_wait_cnt
   import store_size_seq_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int CW = wait_cnt_w(RD_LAT);
   localparam logic [CW-1:0] LOAD_VAL = CW'(RD_LAT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/store_size_seq.sv
// Multicycle control sequencer for stores. Word stores write directly;
// halfword and byte stores read the word, load it into the MDR and then
// write the merged word. Control only; the datapath carries the data.
// Handshake: a request transfers on the rising edge where st_valid and
// st_ready are both high; st_ready is high only in IDLE, and st_addr /
// st_size are sampled only at that edge.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   st_valid/st_ready : request handshake
//   st_addr, st_size  : store address and size (11 behaves as word)
//   st_done           : pulse in the memory write cycle
//   st_err            : pulse when a misaligned halfword is dropped
//   busy              : sequencer is not idle
//   mem_addr          : latched address (0 when idle)
//   mem_rd, mem_wr    : memory strobes
//   mdr_we            : MDR load enable
//   ssize_ctrl        : size select to the store-merge unit
module store_size_seq
   import store_size_seq_pkg::*;
#(
   parameter int AW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [AW-1:0] st_addr,
   input  logic [1:0]    st_size,
   output logic          st_done,
   output logic          st_err,
   output logic          busy,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic          mdr_we,
   output logic [1:0]    ssize_ctrl
);

   state_t        state;
   state_t        next_state;
   logic [AW-1:0] addr_q;
   logic [1:0]    size_q;
   logic          accept;
   logic          cnt_load;
   logic          cnt_dec;
   logic          cnt_zero;

   assign accept = st_valid && (state == IDLE);

   rd_wait_cnt #(.RD_LAT(RD_LAT)) u_rd_wait_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .dec   (cnt_dec),
      .zero  (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         addr_q <= '0;
         size_q <= SZ_WORD;
      end else begin
         state <= next_state;
         if (accept) begin
            addr_q <= st_addr;
            // Fold the reserved code onto word so the merge unit never sees it.
            size_q <= (st_size == 2'b11) ? SZ_WORD : st_size;
         end
      end
   end

   always_comb begin
      next_state = state;
      st_ready   = 1'b0;
      st_done    = 1'b0;
      st_err     = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mdr_we     = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      busy       = (state != IDLE);
      mem_addr   = (state != IDLE) ? addr_q : '0;
      ssize_ctrl = (state != IDLE) ? size_q : SZ_WORD;

      case (state)
         IDLE: begin
            st_ready = 1'b1;
            if (st_valid) begin
               if ((st_size == SZ_HALF) && st_addr[0]) begin
                  next_state = ERR;
               end else if ((st_size == SZ_HALF) || (st_size == SZ_BYTE)) begin
                  next_state = READ;
               end else begin
                  next_state = WRITE;
               end
            end
         end
         READ: begin
            mem_rd     = 1'b1;
            cnt_load   = 1'b1;
            next_state = WAIT;
         end
         WAIT: begin
            cnt_dec = 1'b1;
            // Last wait cycle: read data is valid, MDR captures it at this edge.
            if (cnt_zero) begin
               mdr_we     = 1'b1;
               next_state = WRITE;
            end
         end
         WRITE: begin
            mem_wr     = 1'b1;
            st_done    = 1'b1;
            next_state = IDLE;
         end
         ERR: begin
            st_err     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_store_size_seq.sv
// Bench for store_size_seq: two instances (read latency 1 and 3) share the
// request inputs. The reference expands every accepted request into the
// list of per-cycle output vectors it should produce; idle cycles expect
// the idle vector.
// Vector layout: [40]ready [39]done [38]err [37]busy [36]rd [35]wr [34]mdr_we
//                [33:32]ssize_ctrl [31:0]mem_addr
module tb_store_size_seq;

   localparam int AW = 32;
   typedef logic [40:0] vec_t;
   localparam vec_t IDLE_V = {1'b1, 40'b0};

   logic          clk;
   logic          rst_n;
   logic          st_valid;
   logic [AW-1:0] st_addr;
   logic [1:0]    st_size;

   logic          a_ready, a_done, a_err, a_busy, a_rd, a_wr, a_we;
   logic [AW-1:0] a_addr;
   logic [1:0]    a_ssize;
   logic          b_ready, b_done, b_err, b_busy, b_rd, b_wr, b_we;
   logic [AW-1:0] b_addr;
   logic [1:0]    b_ssize;

   vec_t  exp_q0[$];
   vec_t  exp_q1[$];
   bit    cur_idle[2];
   int    checks;
   int    errors;
   string phase;

   store_size_seq #(.AW(AW), .RD_LAT(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(a_ready),
      .st_addr(st_addr), .st_size(st_size), .st_done(a_done), .st_err(a_err),
      .busy(a_busy), .mem_addr(a_addr), .mem_rd(a_rd), .mem_wr(a_wr),
      .mdr_we(a_we), .ssize_ctrl(a_ssize)
   );

   store_size_seq #(.AW(AW), .RD_LAT(3)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(b_ready),
      .st_addr(st_addr), .st_size(st_size), .st_done(b_done), .st_err(b_err),
      .busy(b_busy), .mem_addr(b_addr), .mem_rd(b_rd), .mem_wr(b_wr),
      .mdr_we(b_we), .ssize_ctrl(b_ssize)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input bit done, input bit err, input bit rd,
                               input bit wr, input bit we, input logic [1:0] sz,
                               input logic [31:0] addr);
      return {1'b0, done, err, 1'b1, rd, wr, we, sz, addr};
   endfunction

   // Expand one accepted request into its expected cycle-by-cycle outputs.
   task automatic push_trace(input int k, input logic [31:0] addr, input logic [1:0] size);
      vec_t tr[$];
      int lat;
      logic [1:0] sz;
      lat = (k == 0) ? 1 : 3;
      sz  = (size == 2'b11) ? 2'b00 : size;
      if (sz == 2'b00) begin
         tr.push_back(mk(1, 0, 0, 1, 0, sz, addr));
      end else if (sz == 2'b01 && addr[0]) begin
         tr.push_back(mk(0, 1, 0, 0, 0, sz, addr));
      end else begin
         tr.push_back(mk(0, 0, 1, 0, 0, sz, addr));
         for (int i = 0; i < lat - 1; i++) tr.push_back(mk(0, 0, 0, 0, 0, sz, addr));
         tr.push_back(mk(0, 0, 0, 0, 1, sz, addr));
         tr.push_back(mk(1, 0, 0, 1, 0, sz, addr));
      end
      foreach (tr[i]) begin
         if (k == 0) exp_q0.push_back(tr[i]);
         else        exp_q1.push_back(tr[i]);
      end
   endtask

   // Reference view of the accept edge.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (rst_n && st_valid && cur_idle[k]) push_trace(k, st_addr, st_size);
      end
   endtask

   // Scoreboard: compare both instances against the head of their queues.
   task automatic check_all();
      vec_t e;
      vec_t a;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            e = (exp_q0.size() != 0) ? exp_q0.pop_front() : IDLE_V;
            a = {a_ready, a_done, a_err, a_busy, a_rd, a_wr, a_we, a_ssize, a_addr};
         end else begin
            e = (exp_q1.size() != 0) ? exp_q1.pop_front() : IDLE_V;
            a = {b_ready, b_done, b_err, b_busy, b_rd, b_wr, b_we, b_ssize, b_addr};
         end
         checks++;
         assert (a === e) else begin
            errors++;
            $error("FAIL %s lat=%0d got %h expected %h", phase, (k == 0) ? 1 : 3, a, e);
         end
         cur_idle[k] = !e[37];
      end
   endtask

   // driver tasks
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input bit v, input logic [31:0] addr, input logic [1:0] size);
      st_valid = v;
      st_addr  = addr;
      st_size  = size;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      cur_idle[0] = 1'b1;
      cur_idle[1] = 1'b1;
      rst_n       = 1'b0;
      phase       = "reset";
      drive(0, 32'h0, 2'b00);
      run(2);
      rst_n = 1'b1;
      run(1);

      phase = "word";
      drive(1, 32'h40, 2'b00);
      cycle();
      drive(0, 32'h0, 2'b00);
      run(2);

      phase = "byte";
      drive(1, 32'h104, 2'b10);
      cycle();
      drive(0, 32'h0, 2'b00);
      run(7);

      phase = "half";
      drive(1, 32'h20, 2'b01);
      cycle();
      drive(0, 32'h0, 2'b00);
      run(7);

      phase = "misaligned";
      drive(1, 32'h21, 2'b01);
      cycle();
      drive(0, 32'h0, 2'b00);
      run(2);

      phase = "back_to_back";
      drive(1, 32'h80, 2'b00);
      cycle();
      drive(1, 32'h85, 2'b10);
      run(2);
      drive(0, 32'h0, 2'b00);
      run(7);

      phase = "size11";
      drive(1, 32'h3c, 2'b11);
      cycle();
      drive(0, 32'h0, 2'b00);
      run(2);

      // Async reset in the middle of a byte store's wait phase.
      phase = "reset_mid_wait";
      drive(1, 32'h200, 2'b10);
      cycle();
      drive(0, 32'h0, 2'b00);
      run(2);
      #2 rst_n = 1'b0;
      #1;
      exp_q0.delete();
      exp_q1.delete();
      check_all();
      run(2);
      rst_n = 1'b1;
      run(8);

      phase = "random";
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1), $urandom, 2'($urandom_range(0, 3)));
         cycle();
      end
      drive(0, 32'h0, 2'b00);
      run(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
